// File: rtl/bit_scan_encoder.sv
// Multi-hot to binary index serializer: accepts a request vector and streams
// the index of every set bit, lowest first, one beat per handshake.
module bit_scan_encoder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none,
    output logic [IDX_W:0]   out_count
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] pend_reg, pend_next;
    logic             out_valid_reg, out_valid_next;
    logic [IDX_W-1:0] out_idx_reg, out_idx_next;
    logic             out_last_reg, out_last_next;
    logic             out_none_reg, out_none_next;
    logic [IDX_W:0]   out_count_reg, out_count_next;
    logic             load_beat;
    logic             accept;
    logic [WIDTH-1:0] lowest_onehot;
    logic [IDX_W-1:0] low_idx;

    function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + (IDX_W+1)'(v[i]);
        end
        return c;
    endfunction

    assign in_ready = (state_reg == IDLE) & ~rst;
    assign accept   = in_valid & in_ready;

    // Isolate the lowest set bit of the next pending vector, then OR-encode it.
    assign lowest_onehot = pend_next & (~pend_next + WIDTH'(1));

    genvar gi, gj;
    generate
        for (gi = 0; gi < IDX_W; gi++) begin : g_enc
            logic [WIDTH-1:0] sel;
            for (gj = 0; gj < WIDTH; gj++) begin : g_sel
                assign sel[gj] = (((gj >> gi) & 1) != 0);
            end
            assign low_idx[gi] = |(lowest_onehot & sel);
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        pend_next      = pend_reg;
        out_valid_next = out_valid_reg;
        out_none_next  = out_none_reg;
        out_count_next = out_count_reg;
        load_beat      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next     = EMIT;
                    pend_next      = in_vec;
                    out_valid_next = 1'b1;
                    out_none_next  = (in_vec == '0);
                    out_count_next = popcount(in_vec);
                    load_beat      = 1'b1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (out_last_reg) begin
                        state_next     = IDLE;
                        pend_next      = '0;
                        out_valid_next = 1'b0;
                        out_none_next  = 1'b0;
                        out_count_next = '0;
                    end else begin
                        // Drop the bit just delivered; next beat follows with no bubble.
                        pend_next = pend_reg & (pend_reg - WIDTH'(1));
                        load_beat = 1'b1;
                    end
                end
            end
            default: begin
                state_next     = IDLE;
                pend_next      = '0;
                out_valid_next = 1'b0;
                out_none_next  = 1'b0;
                out_count_next = '0;
            end
        endcase
    end

    // A zero vector also reads as "last", giving its single out_none beat.
    always_comb begin
        out_idx_next  = out_idx_reg;
        out_last_next = out_last_reg;
        if (load_beat) begin
            out_idx_next  = low_idx;
            out_last_next = ((pend_next & (pend_next - WIDTH'(1))) == '0);
        end else if (state_next == IDLE) begin
            out_idx_next  = '0;
            out_last_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            pend_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_idx_reg   <= '0;
            out_last_reg  <= 1'b0;
            out_none_reg  <= 1'b0;
            out_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            pend_reg      <= pend_next;
            out_valid_reg <= out_valid_next;
            out_idx_reg   <= out_idx_next;
            out_last_reg  <= out_last_next;
            out_none_reg  <= out_none_next;
            out_count_reg <= out_count_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_idx   = out_idx_reg;
    assign out_last  = out_last_reg;
    assign out_none  = out_none_reg;
    assign out_count = out_count_reg;

endmodule

// File: tb/tb_bit_scan_encoder.sv
// Bench for bit_scan_encoder: directed scenarios then random traffic, all
// checked cycle by cycle against a queue of expected beats.
module tb_bit_scan_encoder;

    localparam int W  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_vec;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          out_none;
    logic [IW:0]   out_count;

    bit_scan_encoder #(.WIDTH(W), .IDX_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_none  (out_none),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit last;
        bit none;
        int count;
    } beat_t;

    beat_t q[$];
    int    n_checks = 0;
    int    n_fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected beats: every set bit index in ascending order, or one "none" beat.
    task automatic push_vec(input logic [W-1:0] v);
        int    cnt;
        int    k;
        beat_t b;
        cnt = $countones(v);
        k   = 0;
        if (cnt == 0) begin
            b = '{idx: 0, last: 1'b1, none: 1'b1, count: 0};
            q.push_back(b);
        end else begin
            for (int i = 0; i < W; i++) begin
                if (v[i]) begin
                    k++;
                    b = '{idx: i, last: (k == cnt), none: 1'b0, count: cnt};
                    q.push_back(b);
                end
            end
        end
    endtask

    task automatic cycle();
        bit acc;
        bit hs;
        acc = in_valid && !rst && (q.size() == 0);
        hs  = out_ready && (q.size() != 0);
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
        end else begin
            if (hs) begin
                $display("beat  idx=%0d last=%0d none=%0d count=%0d",
                         q[0].idx, q[0].last, q[0].none, q[0].count);
                void'(q.pop_front());
            end
            if (acc) begin
                $display("accept vec=%h", in_vec);
                push_vec(in_vec);
            end
        end
        chk("in_ready", in_ready, 32'((q.size() == 0) && !rst));
        chk("out_valid", out_valid, 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_idx", out_idx, q[0].idx);
            chk("out_last", out_last, q[0].last);
            chk("out_none", out_none, q[0].none);
            chk("out_count", out_count, q[0].count);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_vec    = 8'hFF;
        out_ready = 1'b1;

        // Reset held with a vector offered: nothing accepted.
        run(2);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_count", out_count, 0);
        rst = 1'b0;
        cycle();
        in_valid = 1'b0;
        run(8);

        // Single bit.
        in_valid = 1'b1;
        in_vec   = 8'b0010_0000;
        cycle();
        in_valid = 1'b0;
        chk("single_idx", out_idx, 5);
        chk("single_last", out_last, 1);
        cycle();
        chk("single_idle", out_valid, 0);

        // Multi-hot, with a second vector waiting on in_valid.
        in_valid = 1'b1;
        in_vec   = 8'b1010_0101;
        cycle();
        in_vec = 8'h01;
        run(4);
        chk("multi_idle_ready", in_ready, 1);
        cycle();
        in_valid = 1'b0;
        chk("second_idx", out_idx, 0);
        cycle();

        // Backpressure.
        in_valid  = 1'b1;
        in_vec    = 8'hC0;
        out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        run(3);
        chk("bp_idx", out_idx, 6);
        chk("bp_last", out_last, 0);
        out_ready = 1'b1;
        cycle();
        chk("bp_next_idx", out_idx, 7);
        run(1);

        // Zero vector.
        in_valid = 1'b1;
        in_vec   = 8'h00;
        cycle();
        in_valid = 1'b0;
        chk("zero_none", out_none, 1);
        run(1);

        // Reset mid-scan.
        in_valid = 1'b1;
        in_vec   = 8'hFF;
        cycle();
        in_valid = 1'b0;
        run(3);
        rst = 1'b1;
        cycle();
        chk("midrst_valid", out_valid, 0);
        rst = 1'b0;
        run(2);
        in_valid = 1'b1;
        in_vec   = 8'h80;
        cycle();
        in_valid = 1'b0;
        chk("after_rst_idx", out_idx, 7);
        chk("after_rst_count", out_count, 1);
        run(2);

        // Random traffic with occasional resets and special vectors.
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 59) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 5))
                0:       in_vec = 8'h00;
                1:       in_vec = 8'hFF;
                2:       in_vec = 8'(1 << $urandom_range(0, 7));
                default: in_vec = 8'($urandom);
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        run(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
